// File: rtl/sb_config_pkg.sv
// rtl/sb_config_pkg.sv - shared types and widths for the switch-box config sequencer
package sb_config_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } sb_seq_state_t;

    localparam int SB_CFG_DATA_WIDTH    = 32;
    localparam int SB_WRITE_COUNT_WIDTH = 16;

endpackage

// File: rtl/sb_config_sequencer_if.sv
// rtl/sb_config_sequencer_if.sv - upstream (addr, word, last) valid/ready stream into the sequencer
interface sb_config_sequencer_if
    import sb_config_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [ADDR_WIDTH-1:0]        cfg_addr;
    logic [SB_CFG_DATA_WIDTH-1:0] cfg_data;
    logic                         cfg_last;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/cfg_onehot_decoder.sv
// rtl/cfg_onehot_decoder.sv - tile index to one-hot strobe decoder with out-of-range flag
module cfg_onehot_decoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_TILES  = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    output logic [NUM_TILES-1:0]  onehot,
    output logic                  out_of_range
);

    // One extra bit keeps the compare valid when NUM_TILES == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] TILE_LIMIT = (ADDR_WIDTH + 1)'(NUM_TILES);

    assign out_of_range = ({1'b0, addr} >= TILE_LIMIT);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (en && ({1'b0, addr} == (ADDR_WIDTH + 1)'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_config_sequencer.sv
// rtl/sb_config_sequencer.sv - writes config words into switch boxes with a one-hot strobe and settle window
module sb_config_sequencer
    import sb_config_pkg::*;
#(
    parameter int NUM_TILES     = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    sb_config_sequencer_if.slave            cfg,
    output logic [SB_CFG_DATA_WIDTH-1:0]    config_data,
    output logic [NUM_TILES-1:0]            config_en,
    output logic                            busy,
    output logic                            done,
    output logic                            err_addr,
    input  logic                            err_clear,
    output logic [SB_WRITE_COUNT_WIDTH-1:0] write_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    sb_seq_state_t                   state_q, state_d;
    logic                            last_q;
    logic [CNT_W-1:0]                settle_cnt_q;
    logic [SB_CFG_DATA_WIDTH-1:0]    config_data_q;
    logic [NUM_TILES-1:0]            config_en_q;
    logic [SB_WRITE_COUNT_WIDTH-1:0] write_count_q;
    logic                            err_addr_q;
    logic                            transfer;
    logic                            addr_oor;
    logic [NUM_TILES-1:0]            strobe_d;

    assign transfer = cfg.cfg_valid && (state_q == IDLE);

    cfg_onehot_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_TILES  (NUM_TILES)
    ) u_decoder (
        .addr         (cfg.cfg_addr),
        .en           (transfer),
        .onehot       (strobe_d),
        .out_of_range (addr_oor)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (!addr_oor)            state_d = WRITE;
                    else if (cfg.cfg_last)    state_d = DONE;
                end
            end
            WRITE: begin
                if (SETTLE_CYCLES > 0)        state_d = SETTLE;
                else if (last_q)              state_d = DONE;
                else                          state_d = IDLE;
            end
            SETTLE: begin
                if (settle_cnt_q == '0)       state_d = last_q ? DONE : IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The strobe is registered straight from the decoder, so it is only ever
    // set on the accepting edge and cleared on the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q        <= 1'b0;
            settle_cnt_q  <= '0;
            config_data_q <= '0;
            config_en_q   <= '0;
            write_count_q <= '0;
            err_addr_q    <= 1'b0;
        end else begin
            config_en_q <= strobe_d;
            if (transfer) begin
                config_data_q <= cfg.cfg_data;
                last_q        <= cfg.cfg_last;
            end
            if (state_q == WRITE) begin
                settle_cnt_q <= SETTLE_LOAD;
            end else if ((state_q == SETTLE) && (settle_cnt_q != '0)) begin
                settle_cnt_q <= settle_cnt_q - CNT_W'(1);
            end
            if ((state_q == WRITE) && (write_count_q != '1)) begin
                write_count_q <= write_count_q + SB_WRITE_COUNT_WIDTH'(1);
            end
            if (transfer && addr_oor) begin
                err_addr_q <= 1'b1;
            end else if (err_clear) begin
                err_addr_q <= 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign config_data   = config_data_q;
    assign config_en     = config_en_q;
    assign err_addr      = err_addr_q;
    assign write_count   = write_count_q;

endmodule

// File: doc/sb_config_sequencer.md
# sb_config_sequencer

Configuration sequencer for the switch-box array. Accepts a stream of (tile address, 32-bit config word) pairs over a valid/ready handshake and, for each word, drives the shared `config_data` bus plus a one-cycle, one-hot `config_en` strobe to the addressed switch box's `sb_config` register. It then holds the bus stable for a programmable settle window. It sits between the chip-level configuration port and the per-tile `config_data`/`config_en` inputs of every switch box.

## Interface
Parameters:
- `NUM_TILES`, 16: number of switch boxes addressed; width of `config_en`.
- `ADDR_WIDTH`, 8: width of `cfg_addr`; must satisfy 2^ADDR_WIDTH >= NUM_TILES.
- `SETTLE_CYCLES`, 2: idle cycles after each strobe, with data held and `config_en` low; 0 is legal and skips the settle phase.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous active-high reset.
- `cfg_valid`, in, 1: upstream word valid.
- `cfg_ready`, out, 1: sequencer can accept a word.
- `cfg_addr`, in, ADDR_WIDTH: target tile index.
- `cfg_data`, in, 32: configuration word.
- `cfg_last`, in, 1: final word of a configuration burst.
- `config_data`, out, 32: shared bus to all switch boxes.
- `config_en`, out, NUM_TILES: one-hot write strobe.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse on burst completion.
- `err_addr`, out, 1: sticky flag; a word with `cfg_addr` >= NUM_TILES was received.
- `err_clear`, in, 1: clears `err_addr`.
- `write_count`, out, 16: number of strobes issued; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: `cfg_ready`=1.
  - WRITE: one cycle; `config_en`[addr]=1.
  - SETTLE: SETTLE_CYCLES cycles; `config_en`=0 and `config_data` held.
  - DONE: one cycle; `done`=1.
- IDLE, transfer (`cfg_valid`&`cfg_ready`):
  - Register addr, data and last; `config_data` takes the new word on the same edge.
  - Addr in range: go to WRITE.
  - Addr out of range: set `err_addr`; no strobe and no count change. Go to DONE if last, else stay in IDLE.
- WRITE:
  - `write_count` increments by 1, saturating.
  - Next state is SETTLE if SETTLE_CYCLES>0; otherwise DONE if last, else IDLE.
- SETTLE:
  - A down-counter loads SETTLE_CYCLES-1 on entry.
  - At 0, go to DONE if last, else IDLE.
- DONE: always returns to IDLE.
- `config_data` holds the last accepted word until the next transfer. It never changes while `config_en` is nonzero.
- `config_en` is at most one-hot in every cycle.
- `err_clear` and a new address error in the same cycle: the set wins. `err_clear` while already clear: no effect.
- `cfg_valid` with `cfg_ready`=0: the word is not consumed; upstream holds it.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `cfg_ready`=1.
  - `config_data`=0, `config_en`=0.
  - `busy`=0, `done`=0, `err_addr`=0.
  - `write_count`=0, settle counter=0.
- Reset mid-operation: any strobe or settle in progress is abandoned immediately. No partial strobe survives.
- Transfer at edge N:
  - `config_en` high in cycle N→N+1.
  - Settle cycles follow.
  - `cfg_ready` returns high SETTLE_CYCLES+1 cycles after N, or +2 on a last word because of DONE.
- Throughput: one word per SETTLE_CYCLES+2 cycles for non-last words.
- Out-of-range non-last word: `cfg_ready` stays high, allowing back-to-back acceptance.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sb_config_pkg`:
  - State enum `sb_seq_state_t` (IDLE, WRITE, SETTLE, DONE).
  - `SB_CFG_DATA_WIDTH`=32.
  - `SB_WRITE_COUNT_WIDTH`=16.
- Sub-module `cfg_onehot_decoder`: parameterised ADDR_WIDTH→NUM_TILES decoder with an enable input and an out-of-range flag output.
- Everything else (FSM, settle counter, count, error flag) lives in the top module.

## Test plan
- Reset then idle: after `reset` deassert, all outputs are at reset values and `cfg_ready`=1; `config_en` stays 0 for 20 cycles.
- Single write, SETTLE_CYCLES=2: addr=5, data=0xDEADBEEF, last=1.
  - `config_en`=0x0020 for exactly one cycle, with `config_data`=0xDEADBEEF.
  - `done` pulses 4 cycles after the accept; `write_count`=1.
- Burst of 16 words, addr 0..15, data=addr*0x01010101, last on the final word, upstream always valid.
  - Each strobe is one-hot with matching data.
  - Accepts are 4 cycles apart; exactly one `done`; `write_count`=16.
- Bad address: addr=20, last=0, followed by addr=3.
  - `err_addr`=1 and no strobe for the bad word.
  - The next word is accepted the following cycle.
  - `err_clear` together with another bad word leaves `err_addr`=1.
- Reset during SETTLE: assert `reset` one cycle after a strobe.
  - Outputs return to reset values asynchronously and no `done` pulse occurs.
  - Next write proceeds normally with `write_count`=1.
- SETTLE_CYCLES=0 variant: back-to-back writes, accepts 2 cycles apart; `write_count` saturation checked by forcing the count to 0xFFFE and issuing 3 writes, ending at 0xFFFF.
